// File: rtl/pa_fdsu_frac_div_pkg.sv
// Shared FDSU definitions for the fraction divider.
// Holds the divider FSM state encodings, significand/quotient widths and the
// single-precision field widths that come from the FPU configuration.
package pa_fdsu_frac_div_pkg;

  localparam int FRAC_WIDTH  = 24;             // significand incl. hidden bit
  localparam int QUO_WIDTH   = FRAC_WIDTH + 2; // int + 23 frac + guard + round
  localparam int CNT_WIDTH   = 5;              // iteration counter width
  localparam int REM_WIDTH   = FRAC_WIDTH + 1; // partial remainder < 2*divisor

  localparam int SINGLE_FRAC = 23;
  localparam int SINGLE_EXPN = 8;

  // Divider FSM encodings.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/pa_fdsu_frac_div_if.sv
// Start/done handshake and operand/result bus of the fraction divider.
// Handshake: div_start is sampled only while the divider is idle; div_kill
// aborts any operation (and wins over a same-cycle start); div_done is a
// one-cycle pulse during which div_quotient/div_sticky/div_err are valid, and
// those results hold until the next accepted start. div_state exposes the FSM.
//   master : drives start/kill/operands, receives status and results
//   slave  : the divider itself
interface pa_fdsu_frac_div_if;
  import pa_fdsu_frac_div_pkg::*;

  logic                  div_start;
  logic                  div_kill;
  logic [FRAC_WIDTH-1:0] div_frac_0;
  logic [FRAC_WIDTH-1:0] div_frac_1;
  logic                  div_busy;
  logic                  div_done;
  logic [QUO_WIDTH-1:0]  div_quotient;
  logic                  div_sticky;
  logic                  div_err;
  logic [1:0]            div_state;

  modport master (
    output div_start, div_kill, div_frac_0, div_frac_1,
    input  div_busy, div_done, div_quotient, div_sticky, div_err, div_state
  );

  modport slave (
    input  div_start, div_kill, div_frac_0, div_frac_1,
    output div_busy, div_done, div_quotient, div_sticky, div_err, div_state
  );
endinterface

// File: rtl/pa_fdsu_frac_div_iter.sv
// One restoring radix-2 division step (combinational).
// Ports:
//   rem      : current partial remainder (always < 2*divisor)
//   divisor  : normalized divisor significand
//   rem_next : remainder for the next step, already shifted left by one
//   q_bit    : quotient bit produced by this step
module pa_fdsu_frac_div_iter
  import pa_fdsu_frac_div_pkg::*;
(
  input  logic [REM_WIDTH-1:0]  rem,
  input  logic [FRAC_WIDTH-1:0] divisor,
  output logic [REM_WIDTH-1:0]  rem_next,
  output logic                  q_bit
);

  // One extra bit so the sign of the trial subtraction is visible.
  logic [REM_WIDTH:0] diff;

  always_comb begin
    diff  = {1'b0, rem} - {2'b00, divisor};
    q_bit = ~diff[REM_WIDTH];
    // A kept difference is < divisor, a restored remainder is < divisor too,
    // so the doubled value still fits in REM_WIDTH bits.
    rem_next = q_bit ? (diff[REM_WIDTH-1:0] << 1) : (rem << 1);
  end

endmodule

// File: rtl/pa_fdsu_frac_div.sv
// Iterative restoring fraction divider for the FDSU datapath.
// Produces floor(a * 2^25 / b) as a 26-bit quotient (bit25 has weight 2^0)
// plus a sticky bit, one quotient bit per cycle.
// Ports:
//   forever_cpuclk : clock
//   cpurst_sync    : synchronous active-high reset
//   div_if         : slave side of the start/kill/done handshake and data bus
module pa_fdsu_frac_div
  import pa_fdsu_frac_div_pkg::*;
(
  input  logic               forever_cpuclk,
  input  logic               cpurst_sync,
  pa_fdsu_frac_div_if.slave  div_if
);

  logic [1:0]            state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [REM_WIDTH-1:0]  rem;
  logic [FRAC_WIDTH-1:0] divisor;
  logic [QUO_WIDTH-1:0]  quo;
  logic                  sticky;
  logic                  err;

  logic [REM_WIDTH-1:0]  rem_next;
  logic                  q_bit;
  logic                  opnd_err;

  pa_fdsu_frac_div_iter u_iter (
    .rem      (rem),
    .divisor  (divisor),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  // An unnormalized operand cannot be divided meaningfully; flag it and
  // report an all-zero result right away instead of iterating.
  assign opnd_err = ~div_if.div_frac_0[FRAC_WIDTH-1] | ~div_if.div_frac_1[FRAC_WIDTH-1];

  always_ff @(posedge forever_cpuclk) begin
    if (cpurst_sync) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      rem     <= '0;
      divisor <= '0;
      quo     <= '0;
      sticky  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (div_if.div_start && !div_if.div_kill) begin
            divisor <= div_if.div_frac_1;
            rem     <= {1'b0, div_if.div_frac_0};
            cnt     <= '0;
            quo     <= '0;
            sticky  <= 1'b0;
            err     <= opnd_err;
            state   <= opnd_err ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          if (div_if.div_kill) begin
            state <= ST_IDLE;
          end else begin
            rem <= rem_next;
            quo <= {quo[QUO_WIDTH-2:0], q_bit};
            cnt <= cnt + CNT_WIDTH'(1);
            if (cnt == CNT_WIDTH'(QUO_WIDTH - 1)) begin
              // Shifting left does not change whether the remainder is zero.
              sticky <= (rem_next != '0);
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign div_if.div_busy     = (state != ST_IDLE);
  assign div_if.div_done     = (state == ST_DONE);
  assign div_if.div_quotient = quo;
  assign div_if.div_sticky   = sticky;
  assign div_if.div_err      = err;
  assign div_if.div_state    = state;

endmodule

// File: tb/tb_pa_fdsu_frac_div.sv
// Bench for pa_fdsu_frac_div: directed cases with literal expectations plus
// randomized operations (with random kills and stray starts) compared every
// cycle against a behavioural model built on plain integer division.
module tb_pa_fdsu_frac_div;

  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  bit   chk_en  = 0;

  pa_fdsu_frac_div_if dif ();

  pa_fdsu_frac_div dut (
    .forever_cpuclk (clk),
    .cpurst_sync    (rst),
    .div_if         (dif)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  // Result packing: {err, sticky, quotient[25:0]}.
  logic [27:0] exp_q[$];
  int          left    = 0;   // cycles until the divider is idle again
  bit          hold_ok = 1;
  logic [27:0] hold_v  = '0;

  function automatic logic [27:0] ref_div(input logic [23:0] a, input logic [23:0] b);
    logic [63:0] num;
    logic [63:0] q;
    if (!a[23] || !b[23]) return {1'b1, 1'b0, 26'd0};
    num = 64'(a) << 25;
    q   = num / 64'(b);
    return {1'b0, (num % 64'(b)) != 0, q[25:0]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      left = 0;
      exp_q.delete();
      hold_ok = 1;
      hold_v  = '0;
    end else if (left == 0) begin
      if (dif.div_start && !dif.div_kill) begin
        logic [27:0] r;
        r = ref_div(dif.div_frac_0, dif.div_frac_1);
        exp_q.push_back(r);
        left    = r[27] ? 1 : 27;
        hold_ok = 0;
      end
    end else if (left == 1) begin
      hold_v  = exp_q.pop_front();
      hold_ok = 1;
      left    = 0;
    end else if (dif.div_kill) begin
      void'(exp_q.pop_back());
      hold_ok = 0;
      left    = 0;
    end else begin
      left--;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(dif.div_busy), 64'(left != 0));
      check("done", 64'(dif.div_done), 64'(left == 1));
      if (left == 1) begin
        if (exp_q.size() == 0) begin
          check("exp_queue_empty", 64'(exp_q.size()), 64'd1);
        end else begin
          check("quotient", 64'(dif.div_quotient), 64'(exp_q[0][25:0]));
          check("sticky",   64'(dif.div_sticky),   64'(exp_q[0][26]));
          check("err",      64'(dif.div_err),      64'(exp_q[0][27]));
        end
      end else if (left == 0 && hold_ok) begin
        check("hold_quotient", 64'(dif.div_quotient), 64'(hold_v[25:0]));
        check("hold_sticky",   64'(dif.div_sticky),   64'(hold_v[26]));
        check("hold_err",      64'(dif.div_err),      64'(hold_v[27]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [23:0] a, input logic [23:0] b);
    @(posedge clk); #1;
    dif.div_frac_0 = a;
    dif.div_frac_1 = b;
    dif.div_start  = 1'b1;
    @(posedge clk); #1;
    dif.div_start  = 1'b0;
  endtask

  // Returns the number of cycles from the accepting edge to div_done, or -1.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (dif.div_done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_op(input logic [23:0] a, input logic [23:0] b, output int lat);
    issue(a, b);
    wait_done(lat);
  endtask

  task automatic directed(input string name, input logic [23:0] a, input logic [23:0] b,
                          input logic [25:0] q_exp, input logic s_exp,
                          input logic e_exp, input int lat_exp);
    int lat;
    do_op(a, b, lat);
    check({name, "_latency"}, 64'(lat), 64'(lat_exp));
    check({name, "_q"},       64'(dif.div_quotient), 64'(q_exp));
    check({name, "_sticky"},  64'(dif.div_sticky),   64'(s_exp));
    check({name, "_err"},     64'(dif.div_err),      64'(e_exp));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst = 1'b1;
    dif.div_start  = 1'b0;
    dif.div_kill   = 1'b0;
    dif.div_frac_0 = '0;
    dif.div_frac_1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("reset_busy", 64'(dif.div_busy), 64'd0);
    check("reset_q",    64'(dif.div_quotient), 64'd0);

    // Literal pins (hand-computed quotients).
    directed("one",     24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0, 27);
    directed("one_5",   24'hC00000, 24'h800000, 26'h3000000, 1'b0, 1'b0, 27);
    directed("two_3rd", 24'h800000, 24'hC00000, 26'h1555555, 1'b1, 1'b0, 27);
    directed("max_a",   24'hFFFFFF, 24'h800000, 26'h3FFFFFC, 1'b0, 1'b0, 27);
    // 2^48 / (2^24-1) = 2^24 + 1 + 1/(2^24-1)
    directed("max_b",   24'h800000, 24'hFFFFFF, 26'h1000001, 1'b1, 1'b0, 27);
    directed("unnorm",  24'h800000, 24'h400000, 26'h0000000, 1'b0, 1'b1, 1);

    // Kill during CALC: idle next cycle, no done pulse (checked by scoreboard).
    issue(24'hC00000, 24'h800000);
    repeat (9) @(posedge clk);
    #1 dif.div_kill = 1'b1;
    @(posedge clk); #1 dif.div_kill = 1'b0;
    @(negedge clk);
    check("kill_busy", 64'(dif.div_busy), 64'd0);
    directed("after_kill", 24'h800000, 24'h800000, 26'h2000000, 1'b0, 1'b0, 27);

    // Start while busy is ignored.
    issue(24'h800000, 24'hC00000);
    repeat (5) @(posedge clk);
    #1 dif.div_start = 1'b1; dif.div_frac_0 = 24'hFFFFFF; dif.div_frac_1 = 24'h800000;
    @(posedge clk); #1 dif.div_start = 1'b0;
    wait_done(lat);
    check("stray_q", 64'(dif.div_quotient), 64'h1555555);

    // Start + kill together while idle: no operation starts.
    @(posedge clk); #1;
    dif.div_start = 1'b1; dif.div_kill = 1'b1;
    @(posedge clk); #1;
    dif.div_start = 1'b0; dif.div_kill = 1'b0;
    @(negedge clk);
    check("start_kill_idle", 64'(dif.div_busy), 64'd0);

    // Reset in mid-operation clears everything.
    issue(24'hC00000, 24'h800000);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 64'(dif.div_busy), 64'd0);
    check("midrst_q",    64'(dif.div_quotient), 64'd0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      logic [23:0] a, b;
      int mode, k;
      a = {1'b1, 23'($urandom)};
      b = {1'b1, 23'($urandom)};
      if ($urandom_range(0, 9) == 0) a[23] = 1'b0;
      if ($urandom_range(0, 9) == 0) b[23] = 1'b0;
      mode = $urandom_range(0, 2);
      if (mode == 2 && (!a[23] || !b[23])) mode = 0;
      case (mode)
        0: begin
          do_op(a, b, lat);
          check("rand_latency", 64'(lat), (!a[23] || !b[23]) ? 64'd1 : 64'd27);
        end
        1: begin
          issue(a, b);
          k = $urandom_range(1, 30);
          repeat (k) @(posedge clk);
          #1 dif.div_kill = 1'b1;
          @(posedge clk); #1 dif.div_kill = 1'b0;
          repeat (2) @(posedge clk);
        end
        default: begin
          issue(a, b);
          k = $urandom_range(2, 20);
          repeat (k) @(posedge clk);
          #1 dif.div_start = 1'b1;
          dif.div_frac_0 = {1'b1, 23'($urandom)};
          dif.div_frac_1 = {1'b1, 23'($urandom)};
          @(posedge clk); #1 dif.div_start = 1'b0;
          wait_done(lat);
          check("rand_stray_timeout", 64'(lat > 0), 64'd1);
        end
      endcase
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
